seq_detect_multi: RTL and testbench
===================================

# seq_detect_multi

Parametrised serial multi-pattern sequence detector; generalises the fixed two-pattern, 7-bit check-bit FSM to NUM_PAT runtime-programmable patterns of PAT_LEN bits. Each pattern has a per-bit mask, and the block supports overlapping and non-overlapping match modes, a qualified input strobe and a saturating match counter. It sits on the serial check-bit path between the bit deserialiser and the frame-control logic, which consumes the match pulse and ID.

## Interface
Parameters:
- PAT_LEN, 7, pattern length in bits (>=2)
- NUM_PAT, 2, number of independent patterns (>=1)
- CNT_W, 8, match counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- x_valid  in  1  qualifies x; bit is consumed only when high
- x  in  1  serial data bit
- cfg_pattern  in  NUM_PAT*PAT_LEN  pattern i at slice [i*PAT_LEN +: PAT_LEN]; bit PAT_LEN-1 = first (oldest) bit
- cfg_mask  in  NUM_PAT*PAT_LEN  1 = compare bit, 0 = don't care; all-zero mask disables pattern i
- cfg_overlap  in  1  1 = overlapping matches, 0 = history flushed after each match
- sync_clr  in  1  clears history/fill only
- clear_cnt  in  1  clears match_cnt
- match  out  1  one-cycle pulse, any pattern matched
- match_vec  out  NUM_PAT  per-pattern match, valid with match
- match_id  out  clog2(NUM_PAT) (min 1)  lowest matching index, held until next match
- match_cnt  out  CNT_W  saturating count of match events

## Operation
- Registers: hist[PAT_LEN-1:0], fill (0..PAT_LEN, saturates), match, match_vec, match_id, match_cnt.
- Accepted bit (x_valid=1): hist_n = {hist[PAT_LEN-2:0], x}; fill_n = min(fill+1, PAT_LEN).
- Lane i hits when x_valid=1, fill_n==PAT_LEN, mask_i!=0, ((hist_n ^ pat_i) & mask_i)==0.
- Any hit: match<=1, match_vec<=hits, match_id<=lowest hit index, match_cnt+=1 (one per event, not per pattern), saturating at all-ones.
- No hit: match<=0, match_vec<=0; match_id holds.
- cfg_overlap=0 and a hit: fill<=0 (hist contents irrelevant); the next match needs PAT_LEN fresh bits. cfg_overlap=1: fill stays PAT_LEN.
- x_valid=0: hist and fill hold, match/match_vec go 0.
- sync_clr: fill<=0, match/match_vec<=0, current bit discarded; match_cnt and match_id are unaffected.
- Priority: reset > sync_clr > bit processing.
- clear_cnt: match_cnt<=0. This beats a simultaneous match increment; match/match_vec/match_id still update.
- Config is sampled combinationally each cycle. Changes are legal only with x_valid=0, and they do not flush history.

## Timing
- Reset values: hist=0, fill=0, match=0, match_vec=0, match_id=0, match_cnt=0.
- Latency: match is high in the cycle after the edge that samples the completing bit, i.e. one registered stage, identical for all lanes.
- The match pulse is exactly one cycle. Back-to-back pulses are possible only with cfg_overlap=1.
- No match is possible until PAT_LEN bits have been accepted since reset, sync_clr or a non-overlap match.
- Reset mid-sequence: partial history is lost; a completing tail alone never matches.

## Structure
- Package seq_detect_pkg:
  - clog2-based width helper
  - Test default patterns: PAT_A=7'b0011111, PAT_B=7'b0100011.
- Sub-module seq_match_lane, instantiated NUM_PAT times in a generate loop:
  - Inputs: hist_n, pat, mask.
  - Output: hit, purely combinational.
- Top level owns the shift register, fill counter, priority encoder and counter.

## Test plan
- PAT_LEN=7, NUM_PAT=2, pat0=0011111, pat1=0100011, masks 7F, overlap=0. Stream 0011111 -> single match pulse one cycle after 7th bit, match_vec=01, match_id=0, match_cnt=1. Then stream 0100011 -> match_vec=10, match_id=1, match_cnt=2.
- pat0=1010101, mask 7F. Stream 10101010101 with overlap=1 -> matches after bits 7, 9, 11, match_cnt=3. Same stream with overlap=0 -> match after bit 7 only, match_cnt=1.
- Bits of 0011111 with x_valid low for 3 cycles between bits 4 and 5 -> no early/extra pulse; match one cycle after 7th valid bit.
- pat1=0011000, mask1=7'b1110000, stream 0011111 -> match_vec=11, match_id=0, match_cnt increments by exactly 1.
- CNT_W=2, 4 non-overlapping matches -> match_cnt=3 (saturated). clear_cnt asserted on the edge of a 5th match -> match_cnt=0, match=1.
- First 5 bits of 0011111, then reset (or sync_clr) for 1 cycle, then bits 11 -> no match. For sync_clr, match_cnt retains its prior value.

Source files
------------

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared definitions for the multi-pattern serial sequence
//                detector: match-ID width helper and the default check-bit
//                patterns used by the frame-control path.
//  Contents    : id_width()  - clog2 with a minimum result of 1
//                PAT_A/PAT_B - default 7-bit check patterns
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  // Width of an index into n items; never narrower than one bit so a
  // single-pattern build still has a legal match_id port.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam logic [6:0] PAT_A = 7'b0011111;
  localparam logic [6:0] PAT_B = 7'b0100011;

endpackage
`default_nettype wire

// File: rtl/seq_match_lane.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_lane
//  Description : Masked comparison of the post-shift history against one
//                programmed pattern. Purely combinational.
//  Ports       : hist_n_i - history including the bit being accepted
//                pat_i    - programmed pattern (MSB = oldest bit)
//                mask_i   - 1 = compare bit, 0 = don't care
//                hit_o    - pattern matches; forced low for an all-zero mask
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_lane
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 7
) (
  input  logic [PAT_LEN-1:0] hist_n_i,
  input  logic [PAT_LEN-1:0] pat_i,
  input  logic [PAT_LEN-1:0] mask_i,
  output logic               hit_o
);

  // An all-zero mask would otherwise match everything; treat it as disabled.
  assign hit_o = (|mask_i) && (((hist_n_i ^ pat_i) & mask_i) == '0);

endmodule
`default_nettype wire

// File: rtl/seq_detect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_multi
//  Description : Serial detector for NUM_PAT runtime-programmable, masked
//                patterns of PAT_LEN bits, with overlapping/non-overlapping
//                modes, qualified input strobe and saturating match counter.
//  Ports       : clock, reset   - rising-edge clock, sync active-high reset
//                x_valid_i, x_i - qualified serial bit
//                cfg_pattern_i  - pattern i at [i*PAT_LEN +: PAT_LEN]
//                cfg_mask_i     - per-bit compare mask, same layout
//                cfg_overlap_i  - 1 = overlapping matches
//                sync_clr_i     - flush history/fill only
//                clear_cnt_i    - clear match counter
//                match_o        - one-cycle pulse, any pattern matched
//                match_vec_o    - per-pattern hits, valid with match_o
//                match_id_o     - lowest matching index, held between matches
//                match_cnt_o    - saturating count of match events
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_multi
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 7,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  localparam int ID_W   = id_width(NUM_PAT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       x_valid_i,
  input  logic                       x_i,
  input  logic [NUM_PAT*PAT_LEN-1:0] cfg_pattern_i,
  input  logic [NUM_PAT*PAT_LEN-1:0] cfg_mask_i,
  input  logic                       cfg_overlap_i,
  input  logic                       sync_clr_i,
  input  logic                       clear_cnt_i,
  output logic                       match_o,
  output logic [NUM_PAT-1:0]         match_vec_o,
  output logic [ID_W-1:0]            match_id_o,
  output logic [CNT_W-1:0]           match_cnt_o
);

  localparam int               FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  // The oldest history bit shifts out on the very bit that completes a
  // window, so only the newest PAT_LEN-1 bits ever need storing.
  logic [PAT_LEN-2:0] hist_q;
  logic [PAT_LEN-1:0] hist_d;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic               match_q;
  logic [NUM_PAT-1:0] match_vec_q;
  logic [ID_W-1:0]    match_id_q;
  logic [CNT_W-1:0]   match_cnt_q;

  logic [NUM_PAT-1:0] lane_hit;
  logic [NUM_PAT-1:0] hits;
  logic               any_hit;
  logic [ID_W-1:0]    first_id;

  assign hist_d = {hist_q, x_i};
  assign fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

  generate
    for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
      seq_match_lane #(
        .PAT_LEN (PAT_LEN)
      ) u_lane (
        .hist_n_i (hist_d),
        .pat_i    (cfg_pattern_i[i*PAT_LEN +: PAT_LEN]),
        .mask_i   (cfg_mask_i[i*PAT_LEN +: PAT_LEN]),
        .hit_o    (lane_hit[i])
      );
    end
  endgenerate

  // Lanes only count on an accepted bit that completes a full window, and
  // never on a cycle whose bit is being discarded by sync_clr.
  assign hits    = lane_hit & {NUM_PAT{x_valid_i && !sync_clr_i && (fill_d == FILL_FULL)}};
  assign any_hit = |hits;

  // Scan from the top down so the lowest hitting index wins.
  always_comb begin
    first_id = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (hits[i]) begin
        first_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_vec_q <= '0;
      match_id_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      if (sync_clr_i) begin
        fill_q      <= '0;
        match_q     <= 1'b0;
        match_vec_q <= '0;
      end else if (x_valid_i) begin
        hist_q      <= hist_d[PAT_LEN-2:0];
        match_q     <= any_hit;
        match_vec_q <= hits;
        if (any_hit) begin
          match_id_q <= first_id;
          // Non-overlap mode restarts the window; stale history is harmless
          // because fill gates every lane until PAT_LEN new bits arrive.
          fill_q     <= cfg_overlap_i ? fill_d : '0;
          if (match_cnt_q != '1) begin
            match_cnt_q <= match_cnt_q + 1'b1;
          end
        end else begin
          fill_q <= fill_d;
        end
      end else begin
        match_q     <= 1'b0;
        match_vec_q <= '0;
      end
      // Last assignment wins over any increment above.
      if (clear_cnt_i) begin
        match_cnt_q <= '0;
      end
    end
  end

  assign match_o     = match_q;
  assign match_vec_o = match_vec_q;
  assign match_id_o  = match_id_q;
  assign match_cnt_o = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_multi
//  Description : Self-checking bench for seq_detect_multi (PAT_LEN=7,
//                NUM_PAT=2, CNT_W=2) against a window-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_multi;
  import seq_detect_pkg::*;

  localparam int PAT_LEN = 7;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              x_valid = 1'b0;
  logic              x = 1'b0;
  logic              cfg_overlap = 1'b0;
  logic              sync_clr = 1'b0;
  logic              clear_cnt = 1'b0;
  logic [13:0]       cfg_pattern;
  logic [13:0]       cfg_mask;
  logic              match;
  logic [1:0]        match_vec;
  logic              match_id;
  logic [CNT_W-1:0]  match_cnt;

  logic [6:0] pat [2];
  logic [6:0] msk [2];

  assign cfg_pattern = {pat[1], pat[0]};
  assign cfg_mask    = {msk[1], msk[0]};

  always #5 clock = ~clock;

  seq_detect_multi #(
    .PAT_LEN (PAT_LEN),
    .NUM_PAT (NUM_PAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .x_valid_i     (x_valid),
    .x_i           (x),
    .cfg_pattern_i (cfg_pattern),
    .cfg_mask_i    (cfg_mask),
    .cfg_overlap_i (cfg_overlap),
    .sync_clr_i    (sync_clr),
    .clear_cnt_i   (clear_cnt),
    .match_o       (match),
    .match_vec_o   (match_vec),
    .match_id_o    (match_id),
    .match_cnt_o   (match_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted bits since the last flush, oldest first.
  int               m_bits[$];
  logic             exp_match = 1'b0;
  logic [1:0]       exp_vec = 2'b00;
  logic             exp_id = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; x_valid = 1'b0; x = 1'b0; sync_clr = 1'b0; clear_cnt = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_bits.delete();
    exp_match = 1'b0; exp_vec = 2'b00; exp_id = 1'b0; exp_cnt = '0;
  endtask

  // Drive one cycle and advance the model; returns #1 after the edge.
  task automatic apply(input logic v, input logic b, input logic sc, input logic cc);
    logic [1:0] h;
    int ok;
    @(negedge clock);
    x_valid = v; x = b; sync_clr = sc; clear_cnt = cc;
    h = 2'b00;
    if (sc) begin
      m_bits.delete();
      exp_match = 1'b0; exp_vec = 2'b00;
    end else if (v) begin
      m_bits.push_back(int'(b));
      if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_LEN) begin
        for (int p = 0; p < NUM_PAT; p++) begin
          ok = (msk[p] != 7'd0) ? 1 : 0;
          for (int k = 0; k < PAT_LEN; k++)
            if (msk[p][PAT_LEN-1-k] && (m_bits[k] != int'(pat[p][PAT_LEN-1-k]))) ok = 0;
          h[p] = (ok != 0);
        end
      end
      exp_match = |h; exp_vec = h;
      if (|h) begin
        exp_id = h[0] ? 1'b0 : 1'b1;
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        if (!cfg_overlap) m_bits.delete();
      end
    end else begin
      exp_match = 1'b0; exp_vec = 2'b00;
    end
    if (cc) exp_cnt = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({match, match_vec, match_id, match_cnt} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_state: got m=%b v=%b id=%b cnt=%0d, want all zero", match, match_vec, match_id, match_cnt);
    end
  endtask

  task automatic test_two_patterns();
    logic [6:0] s;
    pat[0] = PAT_A; pat[1] = PAT_B; msk[0] = 7'h7F; msk[1] = 7'h7F; cfg_overlap = 1'b0;
    for (int r = 0; r < 2; r++) begin
      s = (r == 0) ? PAT_A : PAT_B;
      for (int k = PAT_LEN - 1; k >= 0; k--) begin
        apply(1'b1, s[k], 1'b0, 1'b0);
        n_vec++;
        if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
          n_err++;
          $display("FAIL two_pat r%0d bit%0d: got m=%b v=%b id=%b cnt=%0d want m=%b v=%b id=%b cnt=%0d",
                   r, k, match, match_vec, match_id, match_cnt, exp_match, exp_vec, exp_id, exp_cnt);
        end
      end
      n_vec++;
      if ((r == 0 && {match, match_vec, match_id, match_cnt} !== {1'b1, 2'b01, 1'b0, 2'd1}) ||
          (r == 1 && {match, match_vec, match_id, match_cnt} !== {1'b1, 2'b10, 1'b1, 2'd2})) begin
        n_err++;
        $display("FAIL two_pat_final r%0d: got m=%b v=%b id=%b cnt=%0d", r, match, match_vec, match_id, match_cnt);
      end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (match !== 1'b0 || match_id !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_width: got m=%b id=%b want m=0 id=1", match, match_id);
    end
  endtask

  task automatic test_overlap();
    logic [10:0] s;
    int pulses;
    s = 11'b10101010101;
    pat[0] = 7'b1010101; msk[0] = 7'h7F; msk[1] = 7'h00;
    for (int mode = 1; mode >= 0; mode--) begin
      cfg_overlap = mode[0];
      apply(1'b0, 1'b0, 1'b1, 1'b1);
      pulses = 0;
      for (int k = 10; k >= 0; k--) begin
        apply(1'b1, s[k], 1'b0, 1'b0);
        if (match === 1'b1) pulses++;
        n_vec++;
        if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
          n_err++;
          $display("FAIL overlap%0d bit%0d: got m=%b v=%b id=%b cnt=%0d want m=%b v=%b id=%b cnt=%0d",
                   mode, k, match, match_vec, match_id, match_cnt, exp_match, exp_vec, exp_id, exp_cnt);
        end
      end
      n_vec++;
      if ((mode == 1 && (pulses != 3 || match_cnt !== 2'd3)) ||
          (mode == 0 && (pulses != 1 || match_cnt !== 2'd1))) begin
        n_err++;
        $display("FAIL overlap%0d_count: got pulses=%0d cnt=%0d", mode, pulses, match_cnt);
      end
    end
  endtask

  task automatic test_gaps();
    logic [9:0] v_s, b_s;
    int pulse_at;
    v_s = 10'b1111000111; b_s = 10'b0011000111;
    pat[0] = PAT_A; pat[1] = PAT_B; msk[0] = 7'h7F; msk[1] = 7'h7F; cfg_overlap = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    pulse_at = -1;
    for (int k = 9; k >= 0; k--) begin
      apply(v_s[k], b_s[k], 1'b0, 1'b0);
      if (match === 1'b1) pulse_at = (pulse_at == -1) ? k : 99;
      n_vec++;
      if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
        n_err++;
        $display("FAIL gaps c%0d: got m=%b v=%b cnt=%0d want m=%b v=%b cnt=%0d",
                 k, match, match_vec, match_cnt, exp_match, exp_vec, exp_cnt);
      end
    end
    n_vec++;
    if (pulse_at != 0) begin
      n_err++;
      $display("FAIL gaps_pulse: got pulse code %0d want 0 (single pulse after last valid bit)", pulse_at);
    end
  endtask

  task automatic test_masked();
    logic [6:0] s;
    s = PAT_A;
    pat[1] = 7'b0011000; msk[1] = 7'b1110000;
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = PAT_LEN - 1; k >= 0; k--) begin
      apply(1'b1, s[k], 1'b0, 1'b0);
      n_vec++;
      if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
        n_err++;
        $display("FAIL masked bit%0d: got m=%b v=%b id=%b cnt=%0d want m=%b v=%b id=%b cnt=%0d",
                 k, match, match_vec, match_id, match_cnt, exp_match, exp_vec, exp_id, exp_cnt);
      end
    end
    n_vec++;
    if ({match, match_vec, match_id, match_cnt} !== {1'b1, 2'b11, 1'b0, 2'd1}) begin
      n_err++;
      $display("FAIL masked_final: got m=%b v=%b id=%b cnt=%0d want m=1 v=11 id=0 cnt=1", match, match_vec, match_id, match_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [6:0] s;
    s = PAT_A;
    pat[1] = PAT_B; msk[1] = 7'h7F; cfg_overlap = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int k = PAT_LEN - 1; k >= 0; k--) begin
        apply(1'b1, s[k], 1'b0, (r == 4 && k == 0));
        n_vec++;
        if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
          n_err++;
          $display("FAIL sat r%0d bit%0d: got m=%b cnt=%0d want m=%b cnt=%0d", r, k, match, match_cnt, exp_match, exp_cnt);
        end
      end
      n_vec++;
      if ((r == 3 && match_cnt !== 2'd3) || (r == 4 && (match !== 1'b1 || match_cnt !== 2'd0))) begin
        n_err++;
        $display("FAIL sat_final r%0d: got m=%b cnt=%0d", r, match, match_cnt);
      end
    end
  endtask

  task automatic test_mid_flush();
    logic [6:0] s;
    int pulses;
    s = PAT_A;
    for (int mode = 0; mode < 2; mode++) begin
      if (mode == 1) begin
        for (int k = PAT_LEN - 1; k >= 0; k--) apply(1'b1, s[k], 1'b0, 1'b0);
      end
      for (int k = PAT_LEN - 1; k >= 2; k--) apply(1'b1, s[k], 1'b0, 1'b0);
      if (mode == 0) do_reset();
      else apply(1'b0, 1'b0, 1'b1, 1'b0);
      pulses = 0;
      for (int k = 1; k >= 0; k--) begin
        apply(1'b1, s[k], 1'b0, 1'b0);
        if (match === 1'b1) pulses++;
        n_vec++;
        if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
          n_err++;
          $display("FAIL flush%0d tail%0d: got m=%b cnt=%0d want m=%b cnt=%0d", mode, k, match, match_cnt, exp_match, exp_cnt);
        end
      end
      n_vec++;
      if (pulses != 0 || match_cnt !== ((mode == 0) ? 2'd0 : 2'd1)) begin
        n_err++;
        $display("FAIL flush%0d_tail: got pulses=%0d cnt=%0d want pulses=0 cnt=%0d", mode, pulses, match_cnt, mode);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if (c % 60 == 0) begin
        pat[0] = 7'($urandom); pat[1] = 7'($urandom);
        msk[0] = 7'($urandom & $urandom); msk[1] = 7'($urandom & $urandom);
        if ($urandom_range(0, 5) == 0) msk[1] = 7'h00;
        cfg_overlap = 1'($urandom);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        apply($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);
      end
      n_vec++;
      if ({match, match_vec, match_id, match_cnt} !== {exp_match, exp_vec, exp_id, exp_cnt}) begin
        n_err++;
        $display("FAIL random c%0d: got m=%b v=%b id=%b cnt=%0d want m=%b v=%b id=%b cnt=%0d",
                 c, match, match_vec, match_id, match_cnt, exp_match, exp_vec, exp_id, exp_cnt);
      end
    end
  endtask

  initial begin
    pat[0] = PAT_A; pat[1] = PAT_B; msk[0] = 7'h7F; msk[1] = 7'h7F;
    test_reset();
    test_two_patterns();
    test_overlap();
    test_gaps();
    test_masked();
    test_saturation();
    test_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
